// File: rtl/cpu_pkg.sv
// Shared core definitions: forwarding selects, control-bundle layout and the
// architectural zero register.
package cpu_pkg;

  localparam int unsigned CWidth = 8;

  // Bit offsets inside the opaque EX/MEM/WB control bundle
  localparam int unsigned CTRL_ALU_OP_LSB = 0;
  localparam int unsigned CTRL_ALU_OP_W   = 4;
  localparam int unsigned CTRL_BRANCH     = 4;
  localparam int unsigned CTRL_JUMP       = 5;
  localparam int unsigned CTRL_MEM_WRITE  = 6;
  localparam int unsigned CTRL_WB_PC      = 7;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: ID inputs, in-flight writer info, EX register outputs
// and event counters. master = surrounding pipeline, slave = id_ex_stage.
interface id_ex_stage_if #(
  parameter int unsigned AWidth   = 5,
  parameter int unsigned DWidth   = 32,
  parameter int unsigned CWidth   = 8,
  parameter int unsigned CntWidth = 32
);
  logic              id_valid;
  logic [DWidth-1:0] id_pc;
  logic [AWidth-1:0] id_rs1;
  logic [AWidth-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [AWidth-1:0] id_rd;
  logic [DWidth-1:0] id_rd1;
  logic [DWidth-1:0] id_rd2;
  logic [DWidth-1:0] id_imm;
  logic [CWidth-1:0] id_ctrl;
  logic              id_mem_read;
  logic              id_reg_write;

  logic [DWidth-1:0] ex_result;
  logic              mem_valid;
  logic              mem_reg_write;
  logic [AWidth-1:0] mem_rd;
  logic [DWidth-1:0] mem_result;
  logic              ex_flush;

  logic                stall;
  logic                ex_valid;
  logic [DWidth-1:0]   ex_pc;
  logic [DWidth-1:0]   ex_a;
  logic [DWidth-1:0]   ex_b;
  logic [DWidth-1:0]   ex_imm;
  logic [AWidth-1:0]   ex_rd;
  logic [CWidth-1:0]   ex_ctrl;
  logic                ex_mem_read;
  logic                ex_reg_write;
  logic [CntWidth-1:0] stall_cnt;
  logic [CntWidth-1:0] flush_cnt;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_rd1, id_rd2, id_imm, id_ctrl, id_mem_read, id_reg_write,
           ex_result, mem_valid, mem_reg_write, mem_rd, mem_result, ex_flush,
    input  stall, ex_valid, ex_pc, ex_a, ex_b, ex_imm, ex_rd, ex_ctrl,
           ex_mem_read, ex_reg_write, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_rd1, id_rd2, id_imm, id_ctrl, id_mem_read, id_reg_write,
           ex_result, mem_valid, mem_reg_write, mem_rd, mem_result, ex_flush,
    output stall, ex_valid, ex_pc, ex_a, ex_b, ex_imm, ex_rd, ex_ctrl,
           ex_mem_read, ex_reg_write, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_stage_hazard_fwd_unit.sv
// Combinational load-use hazard detection and operand forwarding select for
// the instruction sitting in ID.
module hazard_fwd_unit
  import cpu_pkg::*;
#(
  parameter int unsigned AWidth = 5
) (
  input  logic              id_valid,
  input  logic [AWidth-1:0] id_rs1,
  input  logic [AWidth-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [AWidth-1:0] ex_rd,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [AWidth-1:0] mem_rd,
  output logic              haz,
  output fwd_sel_t          fwd_a,
  output fwd_sel_t          fwd_b
);

  localparam logic [AWidth-1:0] Zero = AWidth'(REG_ZERO);

  logic ex_load_live;
  logic ex_alu_live;
  logic mem_live;

  always_comb begin
    ex_load_live = ex_valid & ex_mem_read & (ex_rd != Zero);
    ex_alu_live  = ex_valid & ex_reg_write & ~ex_mem_read & (ex_rd != Zero);
    mem_live     = mem_valid & mem_reg_write & (mem_rd != Zero);

    haz = id_valid & ex_load_live &
          ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    // EX is the younger writer, so it wins over MEM
    fwd_a = FWD_RF;
    if (id_use_rs1 & ex_alu_live & (ex_rd == id_rs1)) begin
      fwd_a = FWD_EX;
    end else if (mem_live & (mem_rd == id_rs1)) begin
      fwd_a = FWD_MEM;
    end

    fwd_b = FWD_RF;
    if (id_use_rs2 & ex_alu_live & (ex_rd == id_rs2)) begin
      fwd_b = FWD_EX;
    end else if (mem_live & (mem_rd == id_rs2)) begin
      fwd_b = FWD_MEM;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with operand forwarding, load-use stall,
// flush bubbles and stall/flush event counters.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned AWidth   = 5,
  parameter int unsigned DWidth   = 32,
  parameter int unsigned CWidth   = cpu_pkg::CWidth,
  parameter int unsigned CntWidth = 32
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  logic              haz;
  fwd_sel_t          fwd_a;
  fwd_sel_t          fwd_b;
  logic [DWidth-1:0] op_a;
  logic [DWidth-1:0] op_b;

  hazard_fwd_unit #(.AWidth(AWidth)) u_hazard_fwd (
    .id_valid      (bus.id_valid),
    .id_rs1        (bus.id_rs1),
    .id_rs2        (bus.id_rs2),
    .id_use_rs1    (bus.id_use_rs1),
    .id_use_rs2    (bus.id_use_rs2),
    .ex_valid      (bus.ex_valid),
    .ex_mem_read   (bus.ex_mem_read),
    .ex_reg_write  (bus.ex_reg_write),
    .ex_rd         (bus.ex_rd),
    .mem_valid     (bus.mem_valid),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd        (bus.mem_rd),
    .haz           (haz),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  // Forwarding muxes in front of the EX register
  always_comb begin
    op_a = bus.id_rd1;
    case (fwd_a)
      FWD_EX:  op_a = bus.ex_result;
      FWD_MEM: op_a = bus.mem_result;
      default: op_a = bus.id_rd1;
    endcase

    op_b = bus.id_rd2;
    case (fwd_b)
      FWD_EX:  op_b = bus.ex_result;
      FWD_MEM: op_b = bus.mem_result;
      default: op_b = bus.id_rd2;
    endcase
  end

  // A taken branch squashes the stalled instruction, so no stall is requested
  assign bus.stall = haz & ~bus.ex_flush;

  always_ff @(posedge clk) begin
    if (rst || bus.ex_flush || haz) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_pc        <= '0;
      bus.ex_a         <= '0;
      bus.ex_b         <= '0;
      bus.ex_imm       <= '0;
      bus.ex_rd        <= '0;
      bus.ex_ctrl      <= '0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_reg_write <= 1'b0;
    end else begin
      bus.ex_valid     <= bus.id_valid;
      bus.ex_pc        <= bus.id_pc;
      bus.ex_a         <= op_a;
      bus.ex_b         <= op_b;
      bus.ex_imm       <= bus.id_imm;
      bus.ex_rd        <= bus.id_valid ? bus.id_rd : {AWidth{1'b0}};
      bus.ex_ctrl      <= bus.id_valid ? bus.id_ctrl : {CWidth{1'b0}};
      bus.ex_mem_read  <= bus.id_valid & bus.id_mem_read;
      bus.ex_reg_write <= bus.id_valid & bus.id_reg_write;
    end
  end

  // Event counters wrap naturally at 2^CntWidth
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.stall_cnt <= '0;
      bus.flush_cnt <= '0;
    end else begin
      if (bus.stall) begin
        bus.stall_cnt <= bus.stall_cnt + CntWidth'(1);
      end
      if (bus.ex_flush) begin
        bus.flush_cnt <= bus.flush_cnt + CntWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed ID/writer vectors push expected
// EX-register state; a monitor pops and compares after every clock edge.
module tb_id_ex_stage;

  typedef struct {
    string       tag;
    logic        v;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        mr;
    logic [3:0]  sc;
    logic [3:0]  fc;
    bit          data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  id_ex_stage_if #(.AWidth(5), .DWidth(32), .CWidth(8), .CntWidth(4)) bus ();

  id_ex_stage #(.AWidth(5), .DWidth(32), .CWidth(8), .CntWidth(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic id_set(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic mr, input logic rw);
    bus.id_valid     = v;
    bus.id_pc        = pc;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_use_rs1   = u1;
    bus.id_use_rs2   = u2;
    bus.id_rd        = rd;
    bus.id_rd1       = rd1;
    bus.id_rd2       = rd2;
    bus.id_imm       = pc ^ 32'h0000_000F;
    bus.id_ctrl      = v ? 8'hA5 : 8'h00;
    bus.id_mem_read  = mr;
    bus.id_reg_write = rw;
  endtask

  task automatic mem_set(input logic v, input logic rw, input logic [4:0] rd, input logic [31:0] res);
    bus.mem_valid     = v;
    bus.mem_reg_write = rw;
    bus.mem_rd        = rd;
    bus.mem_result    = res;
  endtask

  // Called just after a falling edge with inputs already applied
  task automatic step(input string tag, input logic e_stall, input logic e_v,
                      input logic [31:0] e_pc, input logic [31:0] e_a, input logic [31:0] e_b,
                      input logic [4:0] e_rd, input logic e_mr, input int e_sc, input int e_fc,
                      input bit e_data);
    exp_t e;
    #1;
    chk({tag, "_stall"}, 64'(bus.stall), 64'(e_stall));
    e.tag = tag; e.v = e_v; e.pc = e_pc; e.a = e_a; e.b = e_b; e.rd = e_rd;
    e.mr = e_mr; e.sc = 4'(e_sc); e.fc = 4'(e_fc); e.data = e_data;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare EX register against the scoreboard after each edge
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        ok = (bus.ex_valid === e.v) && (bus.ex_mem_read === e.mr) &&
             (bus.stall_cnt === e.sc) && (bus.flush_cnt === e.fc);
        if (e.data)
          ok = ok && (bus.ex_pc === e.pc) && (bus.ex_a === e.a) &&
               (bus.ex_b === e.b) && (bus.ex_rd === e.rd);
        if (!ok) begin
          errors++;
          $display("FAIL %s: got v=%0b pc=%h a=%h b=%h rd=%0d mr=%0b sc=%0d fc=%0d, expected v=%0b pc=%h a=%h b=%h rd=%0d mr=%0b sc=%0d fc=%0d",
                   e.tag, bus.ex_valid, bus.ex_pc, bus.ex_a, bus.ex_b, bus.ex_rd,
                   bus.ex_mem_read, bus.stall_cnt, bus.flush_cnt,
                   e.v, e.pc, e.a, e.b, e.rd, e.mr, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    rst = 1'b1;
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_set(0, 0, 0, 0);
    bus.ex_result = '0;
    bus.ex_flush  = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset_ex_valid", 64'(bus.ex_valid), 64'd0);
    chk("reset_ex_pc", 64'(bus.ex_pc), 64'd0);
    chk("reset_ex_a", 64'(bus.ex_a), 64'd0);
    chk("reset_ex_ctrl", 64'(bus.ex_ctrl), 64'd0);
    chk("reset_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("reset_flush_cnt", 64'(bus.flush_cnt), 64'd0);
    rst = 1'b0;

    // Plain capture
    id_set(1, 32'h100, 1, 2, 1, 1, 7, 32'h11, 32'h22, 0, 1);
    step("plain", 0, 1, 32'h100, 32'h11, 32'h22, 7, 0, 0, 0, 1);

    // Forward priority: EX > MEM > regfile, x0 never forwarded
    id_set(1, 32'h104, 0, 0, 0, 0, 5, 0, 0, 0, 1);
    step("ex_wr_x5", 0, 1, 32'h104, 0, 0, 5, 0, 0, 0, 1);
    id_set(1, 32'h108, 5, 6, 1, 1, 8, 32'h55, 32'h66, 0, 0);
    bus.ex_result = 32'hAAAA;
    mem_set(1, 1, 5, 32'hBBBB);
    step("fwd_ex_pri", 0, 1, 32'h108, 32'hAAAA, 32'h66, 8, 0, 0, 0, 1);
    id_set(1, 32'h10C, 5, 0, 1, 0, 0, 32'h55, 0, 0, 0);
    step("fwd_mem", 0, 1, 32'h10C, 32'hBBBB, 0, 0, 0, 0, 0, 1);
    mem_set(0, 0, 0, 0);
    id_set(1, 32'h110, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("ex_wr_x0", 0, 1, 32'h110, 0, 0, 0, 0, 0, 0, 1);
    id_set(1, 32'h114, 0, 0, 1, 1, 0, 32'h77, 32'h88, 0, 0);
    mem_set(1, 1, 0, 32'hBBBB);
    step("fwd_x0", 0, 1, 32'h114, 32'h77, 32'h88, 0, 0, 0, 0, 1);

    // Load-use: stall once, then MEM forwarding covers the load
    mem_set(0, 0, 0, 0);
    bus.ex_result = 32'h5000;
    id_set(1, 32'h200, 2, 0, 1, 0, 3, 32'h1000, 0, 1, 1);
    step("lw", 0, 1, 32'h200, 32'h1000, 0, 3, 1, 0, 0, 1);
    id_set(1, 32'h204, 3, 4, 1, 1, 9, 32'hDEAD, 32'h44, 0, 1);
    step("lu_stall", 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    mem_set(1, 1, 3, 32'h1234);
    step("lu_release", 0, 1, 32'h204, 32'h1234, 32'h44, 9, 0, 1, 0, 1);

    // Flush wins over stall
    mem_set(0, 0, 0, 0);
    id_set(1, 32'h300, 0, 0, 0, 0, 3, 0, 0, 1, 1);
    step("lw2", 0, 1, 32'h300, 0, 0, 3, 1, 1, 0, 1);
    id_set(1, 32'h304, 3, 4, 1, 1, 9, 32'hDEAD, 32'h44, 0, 1);
    bus.ex_flush = 1'b1;
    step("flush", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    bus.ex_flush = 1'b0;

    // Invalid ID never stalls and captures no control
    id_set(1, 32'h380, 0, 0, 0, 0, 3, 0, 0, 1, 1);
    step("lw3", 0, 1, 32'h380, 0, 0, 3, 1, 1, 1, 1);
    id_set(0, 32'h384, 3, 4, 1, 1, 9, 32'hDEAD, 32'h44, 1, 1);
    step("id_invalid", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

    // Reset in the middle of a stall
    id_set(1, 32'h400, 0, 0, 0, 0, 3, 0, 0, 1, 1);
    step("lw4", 0, 1, 32'h400, 0, 0, 3, 1, 1, 1, 1);
    id_set(1, 32'h404, 3, 4, 1, 1, 9, 32'hDEAD, 32'h44, 0, 1);
    rst = 1'b1;
    step("rst_stall", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    step("post_rst", 0, 1, 32'h404, 32'hDEAD, 32'h44, 9, 0, 0, 0, 1);

    // 17 stalls on a 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      id_set(1, 32'h500 + 32'(i * 8), 0, 0, 0, 0, 3, 0, 0, 1, 1);
      step("wrap_lw", 0, 1, 32'h500 + 32'(i * 8), 0, 0, 3, 1, i, 0, 1);
      id_set(1, 32'h504 + 32'(i * 8), 3, 0, 1, 0, 9, 32'hDEAD, 0, 0, 1);
      step("wrap_stall", 1, 0, 0, 0, 0, 0, 0, i + 1, 0, 1);
    end
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("wrap_stall_cnt", 64'(bus.stall_cnt), 64'd1);
    chk("final_flush_cnt", 64'(bus.flush_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
